pipe_adder_tree: RTL and testbench

PIPE_ADDER_TREE -- requirements
Module: pipe_adder_tree

---
 rtl/pipe_adder_tree_pkg.sv | 25 ++
 rtl/adder_tree_stage.sv | 50 +++++
 rtl/pipe_adder_tree.sv | 124 ++++++++++++
 tb/tb_pipe_adder_tree.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_tree_pkg.sv
// Shared constants and width derivations for the pipelined adder tree.
package pipe_adder_tree_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_NUM_IN    = 8;
    localparam int DEF_ACC_EXTRA = 8;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int out_width(input int width, input int num_in);
        return width + log2(num_in);
    endfunction

    function automatic int acc_width(input int width, input int num_in, input int acc_extra);
        return out_width(width, num_in) + acc_extra;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One adder-tree level: pairwise add of adjacent lanes, one bit wider, with
// valid/last registers that hold whenever adv is low.
module adder_tree_stage #(
    parameter int IN_W   = 16,
    parameter int PAIRS  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        adv,
    input  logic                        vld_p0,
    input  logic                        last_p0,
    input  logic [2*PAIRS*IN_W-1:0]     dat_p0,
    output logic                        vld_p1,
    output logic                        last_p1,
    output logic [PAIRS*(IN_W+1)-1:0]   dat_p1
);

    localparam int OUT_W = IN_W + 1;

    logic [PAIRS*OUT_W-1:0] sum;

    function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] a);
        return {SIGNED & a[IN_W-1], a};
    endfunction

    always_comb begin
        sum = '0;
        for (int i = 0; i < PAIRS; i++) begin
            sum[i*OUT_W +: OUT_W] = ext(dat_p0[2*i*IN_W +: IN_W])
                                  + ext(dat_p0[(2*i+1)*IN_W +: IN_W]);
        end
    end

    // p0 -> p1 boundary
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (adv) begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
        end
    end

    always_ff @(posedge CLK) begin
        if (adv) dat_p1 <= sum;
    end

endmodule

// File: rtl/pipe_adder_tree.sv
// Pipelined full-precision adder tree over NUM_IN lanes with a global stall.
// Define PIPE_ADDER_TREE_ACC_EN to append a group accumulator closed by IN_LAST.
module pipe_adder_tree
    import pipe_adder_tree_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_IN    = DEF_NUM_IN,
    parameter int SIGNED    = 0,
    parameter int ACC_EXTRA = DEF_ACC_EXTRA,
    localparam int LEVELS    = log2(NUM_IN),
    localparam int OUT_WIDTH = out_width(WIDTH, NUM_IN),
    localparam int ACC_WIDTH = acc_width(WIDTH, NUM_IN, ACC_EXTRA),
`ifdef PIPE_ADDER_TREE_ACC_EN
    localparam bit ACC_EN    = 1'b1,
`else
    localparam bit ACC_EN    = 1'b0,
`endif
    localparam int DOUT_W    = ACC_EN ? ACC_WIDTH : OUT_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [NUM_IN*WIDTH-1:0]   IN_DATA,
    input  logic                      IN_LAST,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [DOUT_W-1:0]         OUT_DATA,
    output logic                      OUT_LAST
);

    // Bit offset of tree level k (k >= 1) inside the packed level bus.
    function automatic int lvl_off(input int k);
        int off;
        off = 0;
        for (int j = 1; j < k; j++) off += (NUM_IN >> j) * (WIDTH + j);
        return off;
    endfunction

    localparam int TREE_W = lvl_off(LEVELS + 1);

    logic              stall;
    logic              adv;
    logic              accept;
    logic [LEVELS:1]   vld_bus;
    logic [LEVELS:1]   last_bus;
    logic [TREE_W-1:0] tree;
    logic [OUT_WIDTH-1:0] tree_out;

    assign stall    = OUT_VALID & ~OUT_READY;
    assign adv      = ~stall;
    assign IN_READY = ~stall;
    assign accept   = IN_VALID & IN_READY;
    assign tree_out = tree[lvl_off(LEVELS) +: OUT_WIDTH];

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int IW = WIDTH + k - 1;
        localparam int NI = NUM_IN >> (k - 1);

        logic          vld_in;
        logic          last_in;
        logic [NI*IW-1:0] dat_in;

        if (k == 1) begin : g_src
            assign vld_in  = accept;
            assign last_in = IN_LAST;
            assign dat_in  = IN_DATA;
        end else begin : g_src
            assign vld_in  = vld_bus[k-1];
            assign last_in = last_bus[k-1];
            assign dat_in  = tree[lvl_off(k-1) +: NI*IW];
        end

        adder_tree_stage #(
            .IN_W   (IW),
            .PAIRS  (NI / 2),
            .SIGNED (SIGNED != 0)
        ) u_stage (
            .CLK     (CLK),
            .RST     (RST),
            .adv     (adv),
            .vld_p0  (vld_in),
            .last_p0 (last_in),
            .dat_p0  (dat_in),
            .vld_p1  (vld_bus[k]),
            .last_p1 (last_bus[k]),
            .dat_p1  (tree[lvl_off(k) +: (NI/2)*(IW+1)])
        );
    end

`ifdef PIPE_ADDER_TREE_ACC_EN
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] res_q;
    logic                 res_vld;

    assign acc_sum = acc_q
                   + {{ACC_EXTRA{(SIGNED != 0) & tree_out[OUT_WIDTH-1]}}, tree_out};

    // tree -> accumulator boundary; only group totals become visible
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q   <= '0;
            res_vld <= 1'b0;
        end else if (adv) begin
            res_vld <= vld_bus[LEVELS] & last_bus[LEVELS];
            if (vld_bus[LEVELS]) acc_q <= last_bus[LEVELS] ? '0 : acc_sum;
        end
    end

    always_ff @(posedge CLK) begin
        if (adv && vld_bus[LEVELS] && last_bus[LEVELS]) res_q <= acc_sum;
    end

    assign OUT_VALID = res_vld;
    assign OUT_LAST  = res_vld;
    assign OUT_DATA  = res_vld ? res_q : '0;
`else
    assign OUT_VALID = vld_bus[LEVELS];
    assign OUT_LAST  = vld_bus[LEVELS] & last_bus[LEVELS];
    assign OUT_DATA  = vld_bus[LEVELS] ? tree_out : '0;
`endif

endmodule

// File: tb/tb_pipe_adder_tree.sv
// Bench for pipe_adder_tree: scoreboard model plus directed vectors on three
// parameterisations (unsigned 8x16, signed 8x16, unsigned 2x8).
module tb_pipe_adder_tree;

    localparam int W      = 16;
    localparam int N      = 8;
    localparam int LEVELS = 3;
`ifdef PIPE_ADDER_TREE_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif
    localparam int OW   = W + LEVELS;
    localparam int DW   = ACC ? OW + 8 : OW;
    localparam int LAT  = ACC ? LEVELS + 1 : LEVELS;
    localparam int DW2  = ACC ? 9 + 8 : 9;
    localparam int LAT2 = ACC ? 2 : 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [N*W-1:0] in_data;
    logic [DW-1:0]  out_data;

    logic           s_valid, s_ready, s_out_valid, s_out_last;
    logic [N*W-1:0] s_data;
    logic [DW-1:0]  s_out_data;

    logic           n_valid, n_ready, n_out_valid, n_out_last;
    logic [15:0]    n_data;
    logic [DW2-1:0] n_out_data;

    pipe_adder_tree u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_DATA(in_data), .IN_LAST(in_last), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OUT_DATA(out_data), .OUT_LAST(out_last)
    );

    pipe_adder_tree #(.SIGNED(1)) u_sgn (
        .CLK(clk), .RST(rst), .IN_VALID(s_valid), .IN_READY(s_ready),
        .IN_DATA(s_data), .IN_LAST(1'b1), .OUT_VALID(s_out_valid),
        .OUT_READY(1'b1), .OUT_DATA(s_out_data), .OUT_LAST(s_out_last)
    );

    pipe_adder_tree #(.WIDTH(8), .NUM_IN(2)) u_n2 (
        .CLK(clk), .RST(rst), .IN_VALID(n_valid), .IN_READY(n_ready),
        .IN_DATA(n_data), .IN_LAST(1'b1), .OUT_VALID(n_out_valid),
        .OUT_READY(1'b1), .OUT_DATA(n_out_data), .OUT_LAST(n_out_last)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference sum of a beat: plain integer addition of the lane values.
    function automatic longint lane_sum(input logic [N*W-1:0] d, input int lanes,
                                        input int w, input bit sgn);
        longint s;
        longint v;
        s = 0;
        for (int i = 0; i < lanes; i++) begin
            v = 0;
            for (int b = 0; b < w; b++) v[b] = d[i*w + b];
            if (sgn && d[i*w + w - 1]) v = v - (longint'(1) << w);
            s = s + v;
        end
        return s;
    endfunction

    function automatic logic [63:0] trunc(input longint v, input int bits);
        return v & ((longint'(1) << bits) - 1);
    endfunction

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [63:0] got[$];
    longint      acc_m = 0;
    longint      bsum;
    exp_t        e;

    // Scoreboard: results must leave in acceptance order with the model's sums.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            acc_m = 0;
        end else begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", out_valid, 1'b0);
                end else begin
                    check("out_data", out_data, q[0].data);
                    check("out_last", out_last, q[0].last);
                    if (out_ready) begin
                        got.push_back(64'(out_data));
                        void'(q.pop_front());
                    end
                end
            end else begin
                check("idle_data", out_data, 0);
            end
            if (in_valid && in_ready) begin
                bsum = lane_sum(in_data, N, W, 1'b0);
                if (ACC) begin
                    acc_m = acc_m + bsum;
                    if (in_last) begin
                        e.data = trunc(acc_m, DW);
                        e.last = 1'b1;
                        q.push_back(e);
                        acc_m = 0;
                    end
                end else begin
                    e.data = trunc(bsum, DW);
                    e.last = in_last;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic [N*W-1:0] d, input logic v, input logic l);
        @(posedge clk);
        #1;
        in_data  = d;
        in_valid = v;
        in_last  = l;
    endtask

    // Called just after the acceptance edge; lat = edges until a matching result (0 = timeout).
    task automatic wait_out(input bit need_last, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid && (!need_last || out_last)) begin
                lat = i;
                break;
            end
            @(posedge clk);
        end
    endtask

    logic [N*W-1:0] d;
    logic [DW-1:0]  m8;
    int             lat;
    int             seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        s_valid = 1'b0; s_data = '0; n_valid = 1'b0; n_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);

        // lanes 1..8
        d = '0;
        for (int i = 0; i < N; i++) d[i*W +: W] = 16'(i + 1);
        drive(d, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b0);
        wait_out(1'b0, lat);
        check("lat_lanes_1_8", lat, LAT);
        check("sum_lanes_1_8", out_data, 36);

        // all-ones lanes, unsigned
        drive('1, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b0);
        wait_out(1'b0, lat);
        check("sum_all_ones", out_data, 64'h7FFF8);

        // 0xFFFF + 1 must not sign-extend in the unsigned build
        d = '0; d[15:0] = 16'hFFFF; d[31:16] = 16'd1;
        drive(d, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b0);
        wait_out(1'b0, lat);
        check("sum_zero_ext", out_data, 64'h10000);
        repeat (2) @(posedge clk);

        // back-to-back 10, 20, 30 with OUT_READY low in cycles 3..5
        got.delete();
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk);
            #1;
            in_data = '0;
            if (c < 3) in_data[15:0] = 16'((c + 1) * 10);
            in_valid  = (c < 3);
            in_last   = 1'b1;
            out_ready = !(c >= 3 && c <= 5);
            if (c == 4 || c == 5) begin
                @(negedge clk);
                check("stall_in_ready", in_ready, 0);
                check("stall_hold_10", out_data, 10);
            end
        end
        repeat (6) @(posedge clk);
        check("stall_count", got.size(), 3);
        check("stall_first", got[0], 10);
        check("stall_second", got[1], 20);
        check("stall_third", got[2], 30);

        // reset with two beats in flight, plus a beat offered during reset
        got.delete();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            in_data = '0;
            in_data[15:0] = 16'(c + 1);
            in_last  = 1'b1;
            in_valid = (c < 3);
            rst      = (c == 2);
        end
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("quiet_after_rst", seen, 0);
        d = '0; d[15:0] = 16'd40;
        drive(d, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b0);
        wait_out(1'b0, lat);
        check("lat_after_rst", lat, LAT);
        check("sum_after_rst", out_data, 40);
        repeat (2) @(posedge clk);

        // group 5, 7, 9 with LAST on the final beat
        got.delete();
        d = '0; d[15:0] = 16'd2; d[31:16] = 16'd3;
        drive(d, 1'b1, 1'b0);
        d = '0; d[47:32] = 16'd7;
        drive(d, 1'b1, 1'b0);
        d = '0; d[127:112] = 16'd9;
        drive(d, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b0);
        wait_out(1'b1, lat);
        check("lat_group_last", lat, LAT);
        repeat (3) @(posedge clk);
        check("group_count", got.size(), ACC ? 1 : 3);
        check("group_first", got[0], ACC ? 21 : 5);
        check("group_final", got[got.size() - 1], ACC ? 21 : 9);

        // mixed burst with bubbles and intermittent backpressure
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            in_valid = (c < 30) && (c % 5 != 4);
            for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'($urandom);
            in_last   = (c % 3 == 2);
            out_ready = (c % 7 < 4);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (10) @(posedge clk);
        check("drained", q.size(), 0);

        // signed instance: eight -1 lanes, then -1 + 1
        check("sgn_ready", s_ready, 1);
        m8 = '1;
        m8 = m8 << 3;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            #1;
            s_data = t == 0 ? '1 : {112'd0, 16'd1, 16'hFFFF};
            s_valid = 1'b1;
            @(posedge clk);
            #1 s_valid = 1'b0;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (s_out_valid) begin
                    seen = 1;
                    check(t == 0 ? "sgn_minus8" : "sgn_cancel", s_out_data, t == 0 ? m8 : '0);
                    check("sgn_last", s_out_last, 1);
                    break;
                end
            end
            check("sgn_seen", seen, 1);
        end

        // two 8-bit lanes of 255
        check("n2_ready", n_ready, 1);
        @(posedge clk);
        #1;
        n_data = {8'd255, 8'd255};
        n_valid = 1'b1;
        @(posedge clk);
        #1 n_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (n_out_valid) begin
                lat = i;
                check("n2_sum", n_out_data, 510);
                check("n2_last", n_out_last, 1);
                break;
            end
            @(posedge clk);
        end
        check("n2_lat", lat, LAT2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
